// File: rtl/interboard_pkg.sv
// Shared definitions for the inter-board link: message types, word tags,
// word field positions and the receive FSM states.
package interboard_pkg;

  localparam int WORD_W  = 6;
  localparam int TIMER_W = 20;

  typedef logic [2:0] msg_type_t;

  // Message types shared with the transmitter and Game_Master.
  localparam msg_type_t MSG_RESET = 3'd0;
  localparam msg_type_t MSG_KEY   = 3'd1;
  localparam msg_type_t MSG_GUESS = 3'd2;
  localparam msg_type_t MSG_SCORE = 3'd3;

  localparam logic [1:0] TAG_W0 = 2'b10;
  localparam logic [1:0] TAG_W1 = 2'b01;

  // Word 0 = {tag, type[2:0], num[4]}; word 1 = {tag, num[3:0]}.
  localparam int TAG_HI    = 5;
  localparam int TAG_LO    = 4;
  localparam int TYPE_HI   = 3;
  localparam int TYPE_LO   = 1;
  localparam int NUM4_BIT  = 0;
  localparam int NUM_LO_HI = 3;
  localparam int NUM_LO_LO = 0;

  typedef enum logic [1:0] {
    W0_WAIT,
    W0_ACK,
    W1_WAIT,
    W1_ACK
  } rx_state_t;

  function automatic logic [1:0] word_tag(input logic [WORD_W-1:0] w);
    return w[TAG_HI:TAG_LO];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for signals arriving asynchronously to clk.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments so meta and q form a true two-stage
  // shift; blocking here would collapse the chain into a single flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/interboard_receiver.sv
// Receive side of the inter-board link: synchronises the peer's 4-phase
// handshake, reassembles two 6-bit words and delivers one message pulse.
module interboard_receiver
  import interboard_pkg::*;
#(
  parameter logic [TIMER_W-1:0] TIMEOUT_CYC = TIMER_W'(1_000_000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Request_in,
  input  logic [WORD_W-1:0] inter_data_in,
  output logic              Ack_out,
  output logic              interboard_en,
  output logic [2:0]        interboard_msg_type,
  output logic [4:0]        interboard_number,
  output logic              interboard_rst,
  output logic              frame_err
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMEOUT_CYC - TIMER_W'(1);

  logic              req_s;
  logic [WORD_W-1:0] data_s;

  sync_2ff #(.WIDTH(1)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (Request_in),
    .q   (req_s)
  );

  sync_2ff #(.WIDTH(WORD_W)) u_data_sync (
    .clk (clk),
    .rst (rst),
    .d   (inter_data_in),
    .q   (data_s)
  );

  rx_state_t        state;
  logic [TIMER_W-1:0] timer;
  logic             discard;
  msg_type_t        lat_type;
  logic             lat_num4;
  logic [1:0]       tag;

  assign tag = word_tag(data_s);

  // discard also blocks W0_WAIT after an ack timeout until the peer finally
  // releases its request, so a stuck request is never re-accepted as a word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= W0_WAIT;
      timer               <= '0;
      discard             <= 1'b0;
      lat_type            <= MSG_RESET;
      lat_num4            <= 1'b0;
      Ack_out             <= 1'b0;
      interboard_en       <= 1'b0;
      interboard_rst      <= 1'b0;
      interboard_msg_type <= '0;
      interboard_number   <= '0;
      frame_err           <= 1'b0;
    end else begin
      interboard_en  <= 1'b0;
      interboard_rst <= 1'b0;
      frame_err      <= 1'b0;
      // NOTE: default saturating count first; a later "timer <= '0" in the
      // same block overrides it because the last non-blocking write wins.
      if (timer != '1) timer <= timer + TIMER_W'(1);

      unique case (state)
        W0_WAIT: begin
          if (discard) begin
            if (!req_s) discard <= 1'b0;
          end else if (req_s) begin
            Ack_out <= 1'b1;
            timer   <= '0;
            if (tag == TAG_W0) begin
              lat_type <= data_s[TYPE_HI:TYPE_LO];
              lat_num4 <= data_s[NUM4_BIT];
              state    <= W0_ACK;
            end else begin
              frame_err <= 1'b1;
              discard   <= 1'b1;
              state     <= W1_ACK;
            end
          end
        end

        W0_ACK: begin
          if (!req_s) begin
            Ack_out <= 1'b0;
            timer   <= '0;
            state   <= W1_WAIT;
          end else if (timer == TIMER_LAST) begin
            Ack_out   <= 1'b0;
            frame_err <= 1'b1;
            discard   <= 1'b1;
            timer     <= '0;
            state     <= W0_WAIT;
          end
        end

        W1_WAIT: begin
          if (req_s) begin
            Ack_out <= 1'b1;
            timer   <= '0;
            state   <= W1_ACK;
            if (tag == TAG_W1) begin
              if (lat_type == MSG_RESET) begin
                interboard_rst <= 1'b1;
              end else begin
                interboard_en       <= 1'b1;
                interboard_msg_type <= lat_type;
                interboard_number   <= {lat_num4, data_s[NUM_LO_HI:NUM_LO_LO]};
              end
            end else begin
              frame_err <= 1'b1;
              discard   <= 1'b1;
            end
          end else if (timer == TIMER_LAST) begin
            frame_err <= 1'b1;
            timer     <= '0;
            state     <= W0_WAIT;
          end
        end

        W1_ACK: begin
          if (!req_s) begin
            Ack_out <= 1'b0;
            discard <= 1'b0;
            timer   <= '0;
            state   <= W0_WAIT;
          end else if (timer == TIMER_LAST) begin
            Ack_out   <= 1'b0;
            frame_err <= 1'b1;
            discard   <= 1'b1;
            timer     <= '0;
            state     <= W0_WAIT;
          end
        end

        default: state <= W0_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_interboard_receiver.sv
// Self-checking bench for interboard_receiver: directed vector table, timeout
// and reset corner cases, and a randomized word stream against a frame model.
module tb_interboard_receiver;
  import interboard_pkg::*;

  localparam logic [19:0] TO_CYC = 20'd50;

  logic       clk = 1'b0;
  logic       rst;
  logic       Request_in;
  logic [5:0] inter_data_in;
  logic       Ack_out;
  logic       interboard_en;
  logic [2:0] interboard_msg_type;
  logic [4:0] interboard_number;
  logic       interboard_rst;
  logic       frame_err;

  always #5 clk = ~clk;

  interboard_receiver #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .Request_in          (Request_in),
    .inter_data_in       (inter_data_in),
    .Ack_out             (Ack_out),
    .interboard_en       (interboard_en),
    .interboard_msg_type (interboard_msg_type),
    .interboard_number   (interboard_number),
    .interboard_rst      (interboard_rst),
    .frame_err           (frame_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Pulse monitor: counts pulses, records committed messages and flags any
  // violation of the pulse rules.
  int         en_cnt  = 0;
  int         rst_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] en_q[$];
  logic       ack_prev = 1'b0;
  bit         rule_bad = 1'b0;

  always @(negedge clk) begin
    if (interboard_en) begin
      en_cnt++;
      en_q.push_back({interboard_msg_type, interboard_number});
      if (!(Ack_out && !ack_prev)) rule_bad = 1'b1;
    end
    if (interboard_rst) begin
      rst_cnt++;
      if (!(Ack_out && !ack_prev)) rule_bad = 1'b1;
    end
    if (frame_err) err_cnt++;
    if (frame_err && (interboard_en || interboard_rst)) rule_bad = 1'b1;
    if (interboard_en && interboard_rst) rule_bad = 1'b1;
    ack_prev = Ack_out;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic level, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (Ack_out != level && n < 20);
    check(name, n, 3);
  endtask

  task automatic send_word(input logic [5:0] w);
    @(negedge clk);
    inter_data_in = w;
    Request_in    = 1'b1;
    wait_ack(1'b1, "ack_rise_latency");
    Request_in = 1'b0;
    wait_ack(1'b0, "ack_fall_latency");
  endtask

  task automatic check_held(input string name, input int typ, input int num);
    check({name, "_type"}, int'(interboard_msg_type), typ);
    check({name, "_num"}, int'(interboard_number), num);
  endtask

  // Frame-level reference model: words arrive one per handshake; a frame is
  // a tag-10 word followed by a tag-01 word, anything else is a framing error.
  bit         m_in_frame = 1'b0;
  logic [2:0] m_type;
  logic       m_n4;
  logic [7:0] m_exp_q[$];
  int         m_rst = 0;
  int         m_err = 0;

  task automatic model_word(input logic [5:0] w);
    logic [1:0] t;
    t = w[5:4];
    if (!m_in_frame) begin
      if (t == 2'b10) begin
        m_in_frame = 1'b1;
        m_type     = w[3:1];
        m_n4       = w[0];
      end else begin
        m_err++;
      end
    end else begin
      m_in_frame = 1'b0;
      if (t != 2'b01) m_err++;
      else if (m_type == 3'd0) m_rst++;
      else m_exp_q.push_back({m_type, m_n4, w[3:0]});
    end
  endtask

  typedef struct {
    int         nw;
    logic [5:0] w0;
    logic [5:0] w1;
    int         d_en;
    int         d_rst;
    int         d_err;
    int         typ;
    int         num;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, b_en, b_rst, b_err, b_q;
    logic [5:0] w;
    logic [2:0] t;
    logic [4:0] nm;

    vecs[0] = '{2, 6'b10_011_1, 6'b01_0101, 1, 0, 0, 3, 21};
    vecs[1] = '{2, 6'b10_000_0, 6'b01_0000, 0, 1, 0, 3, 21};
    vecs[2] = '{1, 6'b11_0110, 6'b00_0000, 0, 0, 1, 3, 21};
    vecs[3] = '{2, 6'b10_101_0, 6'b01_1100, 1, 0, 0, 5, 12};
    vecs[4] = '{2, 6'b10_010_1, 6'b11_0000, 0, 0, 1, 5, 12};
    vecs[5] = '{2, 6'b10_111_1, 6'b01_1111, 1, 0, 0, 7, 31};
    vecs[6] = '{2, 6'b10_000_1, 6'b01_1010, 0, 1, 0, 7, 31};
    vecs[7] = '{2, 6'b10_001_0, 6'b01_0000, 1, 0, 0, 1, 0};

    rst = 1'b1;
    Request_in = 1'b0;
    inter_data_in = '0;
    idle(3);
    check("reset_ack", int'(Ack_out), 0);
    check("reset_en", int'(interboard_en), 0);
    check("reset_rst", int'(interboard_rst), 0);
    check("reset_err", int'(frame_err), 0);
    check_held("reset", 0, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      b_en = en_cnt; b_rst = rst_cnt; b_err = err_cnt;
      send_word(vecs[i].w0);
      if (vecs[i].nw == 2) send_word(vecs[i].w1);
      idle(3);
      check("vec_en_pulses", en_cnt - b_en, vecs[i].d_en);
      check("vec_rst_pulses", rst_cnt - b_rst, vecs[i].d_rst);
      check("vec_err_pulses", err_cnt - b_err, vecs[i].d_err);
      check_held("vec", vecs[i].typ, vecs[i].num);
    end

    // Word 0 only: word 1 never arrives.
    b_en = en_cnt; b_err = err_cnt;
    send_word(6'b10_100_0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_err && n < 100);
    check("w1_timeout_cycles", n, 50);
    idle(2);
    check("w1_timeout_no_commit", en_cnt - b_en, 0);
    check("w1_timeout_err", err_cnt - b_err, 1);
    send_word(6'b10_100_0);
    send_word(6'b01_0110);
    idle(2);
    check("after_w1_timeout_en", en_cnt - b_en, 1);
    check_held("after_w1_timeout", 4, 6);

    // Request stuck high during word 0.
    b_en = en_cnt; b_rst = rst_cnt; b_err = err_cnt;
    @(negedge clk);
    inter_data_in = 6'b10_110_0;
    Request_in = 1'b1;
    wait_ack(1'b1, "stuck_ack_rise");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_err && n < 100);
    check("ack_timeout_cycles", n, 50);
    check("ack_drop_at_timeout", int'(Ack_out), 0);
    repeat (10) @(negedge clk);
    check("stuck_no_reaccept", int'(Ack_out), 0);
    Request_in = 1'b0;
    idle(6);
    check("stuck_no_en", en_cnt - b_en, 0);
    check("stuck_no_rst", rst_cnt - b_rst, 0);
    check("stuck_err", err_cnt - b_err, 1);
    send_word(6'b10_110_0);
    send_word(6'b01_0010);
    idle(2);
    check("after_stuck_en", en_cnt - b_en, 1);
    check_held("after_stuck", 6, 2);

    // Reset while word 0 is being acknowledged.
    b_en = en_cnt; b_rst = rst_cnt;
    @(negedge clk);
    inter_data_in = 6'b10_011_0;
    Request_in = 1'b1;
    wait_ack(1'b1, "midreset_ack_rise");
    #2 rst = 1'b1;
    #1;
    check("midreset_ack_async", int'(Ack_out), 0);
    check_held("midreset", 0, 0);
    Request_in = 1'b0;
    idle(2);
    @(negedge clk);
    rst = 1'b0;
    send_word(6'b10_010_1);
    send_word(6'b01_0011);
    idle(2);
    check("midreset_en", en_cnt - b_en, 1);
    check("midreset_rst", rst_cnt - b_rst, 0);
    check_held("midreset_frame", 2, 19);

    // Request already high when reset deasserts.
    b_en = en_cnt;
    @(negedge clk);
    rst = 1'b1;
    inter_data_in = 6'b10_100_1;
    Request_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ack(1'b1, "req_out_of_reset_rise");
    Request_in = 1'b0;
    wait_ack(1'b0, "req_out_of_reset_fall");
    send_word(6'b01_0001);
    idle(2);
    check("req_out_of_reset_en", en_cnt - b_en, 1);
    check_held("req_out_of_reset", 4, 17);

    // Randomized word stream against the frame model.
    b_en = en_cnt; b_rst = rst_cnt; b_err = err_cnt; b_q = en_q.size();
    for (int i = 0; i < 50; i++) begin
      if ($urandom_range(0, 9) < 6) begin
        t  = 3'($urandom_range(0, 7));
        nm = 5'($urandom_range(0, 31));
        w  = {2'b10, t, nm[4]};
        model_word(w);
        send_word(w);
        repeat ($urandom_range(0, 8)) @(negedge clk);
        w = {2'b01, nm[3:0]};
      end else begin
        w = 6'($urandom_range(0, 63));
      end
      model_word(w);
      send_word(w);
      repeat ($urandom_range(0, 8)) @(negedge clk);
    end
    if (m_in_frame) begin
      idle(60);
      m_err++;
      m_in_frame = 1'b0;
    end else begin
      idle(5);
    end
    check("rand_en_count", en_cnt - b_en, m_exp_q.size());
    check("rand_rst_count", rst_cnt - b_rst, m_rst);
    check("rand_err_count", err_cnt - b_err, m_err);
    for (int k = 0; k < m_exp_q.size(); k++) begin
      if (b_q + k < en_q.size())
        check("rand_msg", int'(en_q[b_q + k]), int'(m_exp_q[k]));
    end

    check("pulse_rules", int'(rule_bad), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
